gray_seq_ctrl: RTL and testbench

Sequencer for the team's binary-to-Gray encoder datapath (x=b[2], y=b[2]^b[1], z=b[1]^b[0], generalised to WIDTH bits). It steps a binary index between programmable bounds, up or down, once or looping. It presents each index and its Gray code to a downstream consumer over a valid/ready handshake. It sits between the control/CSR logic that issues start/stop and any Gray-coded consumer, such as a pointer-sync or encoder test path.

---
 rtl/gray_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a binary index between programmable bounds (up or
// down, single pass or looping) and offers each index plus its Gray code to a
// downstream consumer over a valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle request to begin; ignored while busy
//   stop            abort the running sequence; no effect when idle
//   dir, loop       direction (0 up, 1 down) and loop mode, sampled on start
//   lo, hi          inclusive bounds, sampled on start
//   ready           consumer accepts the current word
//   out_bin         current index (registered)
//   out_gray        out_bin ^ (out_bin >> 1) (registered)
//   valid           out_bin/out_gray hold a word to transfer
//   busy            high while loading or emitting
//   done            one-cycle pulse when a non-looping sequence completes
//   wrap            one-cycle pulse when a looping sequence restarts
//   err             (GRAY_SEQ_CHECK_EN only) sticky flag, set when two
//                   consecutive transferred Gray words within a pass differ
//                   in other than exactly one bit
//
// Build option: define GRAY_SEQ_CHECK_EN to add the err output and checker.
module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             loop,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             ready,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             wrap
`ifdef GRAY_SEQ_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned W = WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           dir_q, dir_d;
  logic           loop_q, loop_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [W-1:0]   gray_q, gray_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wrap_q, wrap_d;

  logic [W-1:0]   first_idx_c;
  logic [W-1:0]   last_idx_c;
  logic           at_last_c;
  logic           xfer_c;

  // Pass endpoints depend on the captured direction.
  assign first_idx_c = dir_q ? hi_q : lo_q;
  assign last_idx_c  = dir_q ? lo_q : hi_q;
  assign at_last_c   = (bin_q == last_idx_c);
  // Only meaningful in EMIT; stop suppresses the transfer.
  assign xfer_c      = valid_q & ready & ~stop;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    loop_d  = loop_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          dir_d   = dir;
          loop_d  = loop;
          lo_d    = lo;
          hi_d    = hi;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          busy_d  = 1'b0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          bin_d = first_idx_c;
          if (lo_q > hi_q) begin
            // Empty range: no word is ever offered.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            valid_d = 1'b1;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (xfer_c) begin
          if (at_last_c) begin
            if (loop_q) begin
              bin_d  = first_idx_c;
              wrap_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            // Bounds are checked before stepping, so this never wraps.
            bin_d = dir_q ? (bin_q - W'(1)) : (bin_q + W'(1));
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      loop_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      loop_q  <= loop_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out_bin  = bin_q;
  assign out_gray = gray_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap     = wrap_q;

`ifdef GRAY_SEQ_CHECK_EN
  logic           err_q, err_d;
  logic           have_prev_q, have_prev_d;
  logic [W-1:0]   prev_gray_q, prev_gray_d;
  logic [W-1:0]   diff_c;
  logic           one_bit_c;

  assign diff_c    = gray_q ^ prev_gray_q;
  assign one_bit_c = (diff_c != '0) && ((diff_c & (diff_c - W'(1))) == '0);

  // Compare each transferred Gray word with the previous one of the same pass.
  always_comb begin
    err_d       = err_q;
    have_prev_d = have_prev_q;
    prev_gray_d = prev_gray_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d       = 1'b0;
      have_prev_d = 1'b0;
    end else if ((state_q == ST_EMIT) && xfer_c) begin
      if (have_prev_q && !one_bit_c) begin
        err_d = 1'b1;
      end
      prev_gray_d = gray_q;
      // The word after a pass end starts a new pass, so skip that pair.
      have_prev_d = ~at_last_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      have_prev_q <= 1'b0;
      prev_gray_q <= '0;
    end else begin
      err_q       <= err_d;
      have_prev_q <= have_prev_d;
      prev_gray_q <= prev_gray_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: the stimulus process pushes the expected
// event stream (words, wrap pulses, done pulse) and a negedge monitor pops and
// compares whenever the DUT presents an event.
module tb_gray_seq_ctrl;

  localparam int unsigned W = 3;
  localparam int unsigned N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         dir = 1'b0;
  logic         loop = 1'b0;
  logic [W-1:0] lo = '0;
  logic [W-1:0] hi = '0;
  logic         ready = 1'b0;
  logic [W-1:0] out_bin;
  logic [W-1:0] out_gray;
  logic         valid;
  logic         busy;
  logic         done;
  logic         wrap;
`ifdef GRAY_SEQ_CHECK_EN
  logic         err;
`endif

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .loop     (loop),
    .lo       (lo),
    .hi       (hi),
    .ready    (ready),
    .out_bin  (out_bin),
    .out_gray (out_gray),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
`ifdef GRAY_SEQ_CHECK_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WORD, EV_WRAP, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       bin;
    int       gray;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  gtab[N];

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void sb_pop(input ev_kind_e k, input string nm, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{EV_WORD, 0, 0};
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event %s, required nothing (t=%0t)", nm, k.name(), $time);
    end else if (sb_q[0].kind != k) begin
      errors++;
      $display("FAIL %s: got event %s, required %s (t=%0t)", nm, k.name(), sb_q[0].kind.name(), $time);
    end else begin
      e  = sb_q.pop_front();
      ok = 1'b1;
    end
  endfunction

  // Reference: index sequence of a pass, repeated for looping runs.
  function automatic int seq_at(input int lo_v, input int hi_v, input bit dir_v, input int idx);
    int n;
    int p;
    n = hi_v - lo_v + 1;
    p = idx % n;
    return dir_v ? (hi_v - p) : (lo_v + p);
  endfunction

  function automatic void push_word(input int b);
    sb_q.push_back('{EV_WORD, b, gtab[b]});
  endfunction

  function automatic int count_words();
    int c;
    c = 0;
    foreach (sb_q[i]) if (sb_q[i].kind == EV_WORD) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bin"},   int'(out_bin),  0);
    chk({tag, "_gray"},  int'(out_gray), 0);
    chk({tag, "_valid"}, int'(valid),    0);
    chk({tag, "_busy"},  int'(busy),     0);
    chk({tag, "_done"},  int'(done),     0);
    chk({tag, "_wrap"},  int'(wrap),     0);
`ifdef GRAY_SEQ_CHECK_EN
    chk({tag, "_err"},   int'(err),      0);
`endif
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    ready = 1'b0;
    sb_q.delete();
    tick();
    tick();
    chk_all_zero("reset");
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drive_rand(input int pct, input bit extra);
    ready = (int'($urandom_range(99)) < pct);
    start = extra && ($urandom_range(3) == 0);
    lo    = W'($urandom);
    hi    = W'($urandom);
    dir   = 1'($urandom);
    loop  = 1'($urandom);
  endtask

  // One sequence: k words are expected before a stop, unless the run completes.
  task automatic run(input int lo_v, input int hi_v, input bit dir_v, input bit loop_v,
                     input int k, input int pct, input bit extra);
    int n;
    bit full;
    bit fin;
    int stop_bin;
    n        = (lo_v <= hi_v) ? (hi_v - lo_v + 1) : 0;
    full     = (n == 0) || (!loop_v && k >= n);
    stop_bin = 0;
    if (n == 0) begin
      sb_q.push_back('{EV_DONE, 0, 0});
    end else if (full) begin
      for (int i = 0; i < n; i++) push_word(seq_at(lo_v, hi_v, dir_v, i));
      sb_q.push_back('{EV_DONE, 0, 0});
    end else begin
      for (int i = 0; i < k; i++) begin
        push_word(seq_at(lo_v, hi_v, dir_v, i));
        if (loop_v && ((i + 1) % n == 0)) sb_q.push_back('{EV_WRAP, 0, 0});
      end
      stop_bin = seq_at(lo_v, hi_v, dir_v, k);
    end

    lo    = W'(lo_v);
    hi    = W'(hi_v);
    dir   = dir_v;
    loop  = loop_v;
    stop  = 1'b0;
    ready = (int'($urandom_range(99)) < pct);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy",  int'(busy),  1);
    chk("load_valid", int'(valid), 0);
    drive_rand(pct, extra);
    tick();
    if (n > 0) begin
      chk("first_valid", int'(valid), 1);
    end else begin
      chk("empty_done",  int'(done),  1);
      chk("empty_valid", int'(valid), 0);
      chk("empty_busy",  int'(busy),  0);
    end

    fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (full) begin
        if (sb_q.size() == 0) fin = 1'b1;
      end else if (count_words() == 0) begin
        stop  = 1'b1;
        start = 1'b0;
        ready = 1'($urandom);
        tick();
        stop = 1'b0;
        chk("stop_valid", int'(valid),   0);
        chk("stop_busy",  int'(busy),    0);
        chk("stop_bin",   int'(out_bin), stop_bin);
        fin = 1'b1;
      end
      if (!fin) begin
        drive_rand(pct, extra);
        tick();
      end
    end
    start = 1'b0;

    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d events pending, required 0 (lo=%0d hi=%0d)", sb_q.size(), lo_v, hi_v);
      reset_dut();
    end else if (full) begin
      chk("idle_busy",  int'(busy),  0);
      chk("idle_valid", int'(valid), 0);
    end
  endtask

  // Monitor: decoupled checker driven by what the DUT presents.
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_bin = '0;

  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      chk("gray_map", int'(out_gray), gtab[out_bin]);
`ifdef GRAY_SEQ_CHECK_EN
      chk("err_low", int'(err), 0);
`endif
      if (prev_hold) begin
        chk("hold_valid", int'(valid),   1);
        chk("hold_bin",   int'(out_bin), int'(prev_bin));
      end
      if (wrap) sb_pop(EV_WRAP, "wrap", e, ok);
      if (valid && sb_q.size() > 0 && sb_q[0].kind == EV_DONE)
        chk("valid_after_last", int'(valid), 0);
      if (valid && ready && !stop) begin
        sb_pop(EV_WORD, "xfer", e, ok);
        if (ok) begin
          chk("xfer_bin",  int'(out_bin),  e.bin);
          chk("xfer_gray", int'(out_gray), e.gray);
        end
      end
      if (done) sb_pop(EV_DONE, "done", e, ok);
      prev_hold = valid && !ready && !stop;
      prev_bin  = out_bin;
    end
  end

  initial begin
    int lo_v;
    int hi_v;
    int n;
    int k;
    bit lp;

    // Gray table by reflection: second half mirrors the first with the top bit set.
    gtab[0] = 0;
    for (int b = 1; b <= int'(W); b++) begin
      int half;
      half = 1 << (b - 1);
      for (int i = 0; i < half; i++) gtab[half + i] = half | gtab[half - 1 - i];
    end

    reset_dut();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_after_reset_busy", int'(busy), 0);
    end

    run(0, 7, 1'b0, 1'b0, 8, 100, 1'b0);
    run(2, 5, 1'b1, 1'b0, 4, 100, 1'b0);
    run(5, 2, 1'b0, 1'b0, 0, 100, 1'b0);
    run(0, 3, 1'b0, 1'b0, 4, 50, 1'b0);
    run(6, 7, 1'b0, 1'b1, 7, 100, 1'b0);
    run(4, 4, 1'b1, 1'b1, 3, 100, 1'b0);
    run(0, 7, 1'b0, 1'b0, 2, 100, 1'b1);
    run(0, 7, 1'b0, 1'b0, 8, 100, 1'b0);

    for (int r = 0; r < 40; r++) begin
      lo_v = int'($urandom_range(7));
      if ($urandom_range(9) == 0) hi_v = int'($urandom_range(7));
      else hi_v = int'($urandom_range(7, lo_v));
      n  = (lo_v <= hi_v) ? (hi_v - lo_v + 1) : 0;
      lp = 1'($urandom);
      if (n == 0) k = 0;
      else if (lp) k = int'($urandom_range(3 * n, 1));
      else k = int'($urandom_range(n + 1, 1));
      run(lo_v, hi_v, 1'($urandom), lp, k, int'($urandom_range(100, 30)), 1'($urandom));
    end

    // Asynchronous reset in the middle of an emitting sequence.
    lo    = 3'd0;
    hi    = 3'd7;
    dir   = 1'b0;
    loop  = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(i);
    sb_q.push_back('{EV_DONE, 0, 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_reset_valid", int'(valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sb_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_busy",  int'(busy),  0);
      chk("post_reset_valid", int'(valid), 0);
    end
    run(1, 6, 1'b1, 1'b0, 6, 80, 1'b1);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
